// File: rtl/lfsr_pkg.sv
// Constants and the checker state type shared by the 8-bit PRBS generator and prbs_chk.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hFE;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // Next stream bit: XOR of sr[7:1]. The register shifts up and inserts at sr[0].
  function automatic logic lfsr_predict(input logic [LFSR_W-1:0] sr);
    return ^(sr & TAP_MASK);
  endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module prbs_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/prbs_chk.sv
// PRBS checker for the 8-bit lfsr_pkg stream: FILL -> SEARCH -> LOCKED with windowed loss detection.
// Optional PRBS_CHK_ERR_CLR_EN adds err_clr, a synchronous clear of err_cnt.
module prbs_chk
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_bit,
  input  logic             in_vld,
`ifdef PRBS_CHK_ERR_CLR_EN
  input  logic             err_clr,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FW  = $clog2(LFSR_W);
  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int WCW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int WEW = $clog2(LOSS_THR + 1);

  chk_state_e        state_reg;
  logic [LFSR_W-1:0] sr_reg;
  logic [FW-1:0]     fill_cnt_reg;
  logic [MCW-1:0]    match_cnt_reg;
  logic [WCW-1:0]    win_cnt_reg;
  logic [WEW-1:0]    win_err_reg;
  logic              locked_reg;
  logic              err_pulse_reg;

  logic              predicted;
  logic              mismatch;
  logic              win_wrap;
  logic [WEW-1:0]    win_err_base;
  logic [WEW-1:0]    win_err_next;
  logic              loss;
  logic              err_inc;
  logic              err_clr_int;

  always_comb begin
    predicted    = lfsr_predict(sr_reg);
    mismatch     = in_bit ^ predicted;
    win_wrap     = (win_cnt_reg == WCW'(LOSS_WIN - 1));
    // A mismatch on the wrap beat is the first error of the new window.
    win_err_base = win_wrap ? '0 : win_err_reg;
    win_err_next = win_err_base + WEW'(mismatch);
    loss         = (win_err_next == WEW'(LOSS_THR));
    err_inc      = in_vld && (state_reg == ST_LOCKED) && mismatch;
  end

`ifdef PRBS_CHK_ERR_CLR_EN
  assign err_clr_int = err_clr;
`else
  assign err_clr_int = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg     <= ST_FILL;
      sr_reg        <= '0;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (in_vld) begin
        case (state_reg)
          ST_FILL: begin
            sr_reg <= {sr_reg[LFSR_W-2:0], in_bit};
            if (fill_cnt_reg == FW'(LFSR_W - 1)) begin
              fill_cnt_reg <= '0;
              state_reg    <= ST_SEARCH;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + FW'(1);
            end
          end
          ST_SEARCH: begin
            sr_reg <= {sr_reg[LFSR_W-2:0], in_bit};
            // An all-zero register predicts zeros forever, so such matches never count.
            if (!mismatch && (sr_reg != '0)) begin
              if (match_cnt_reg == MCW'(LOCK_CNT - 1)) begin
                match_cnt_reg <= '0;
                win_cnt_reg   <= '0;
                win_err_reg   <= '0;
                locked_reg    <= 1'b1;
                state_reg     <= ST_LOCKED;
              end else begin
                match_cnt_reg <= match_cnt_reg + MCW'(1);
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-running on the prediction so one flipped bit costs exactly one error.
            sr_reg        <= {sr_reg[LFSR_W-2:0], predicted};
            err_pulse_reg <= mismatch;
            if (loss) begin
              state_reg     <= ST_FILL;
              locked_reg    <= 1'b0;
              fill_cnt_reg  <= '0;
              match_cnt_reg <= '0;
              win_cnt_reg   <= '0;
              win_err_reg   <= '0;
            end else begin
              win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + WCW'(1);
              win_err_reg <= win_err_next;
            end
          end
          default: begin
            state_reg  <= ST_FILL;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  prbs_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (err_clr_int),
    .inc  (err_inc),
    .cnt  (err_cnt)
  );

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_prbs_chk.sv
// Directed bench for prbs_chk: vector table for lock/single error, hand sequences for the corners.
module tb_prbs_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic        in_bit;
  logic        in_vld;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked2, err_pulse2;
  logic [1:0]  err_cnt2;
`ifdef PRBS_CHK_ERR_CLR_EN
  logic        err_clr;
`endif

  prbs_chk dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_bit    (in_bit),
    .in_vld    (in_vld),
`ifdef PRBS_CHK_ERR_CLR_EN
    .err_clr   (err_clr),
`endif
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  // Narrow counter and lax threshold: exercises saturation without losing lock.
  prbs_chk #(.LOCK_CNT(16), .LOSS_WIN(64), .LOSS_THR(8), .ERR_W(2)) dut2 (
    .clk       (clk),
    .rst_      (rst_),
    .in_bit    (in_bit),
    .in_vld    (in_vld),
`ifdef PRBS_CHK_ERR_CLR_EN
    .err_clr   (err_clr),
`endif
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_cnt   (err_cnt2)
  );

  typedef struct {
    logic        vld;
    logic        flip;
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the reference generator on valid beats, optionally corrupt the bit.
  task automatic beat(input logic vld, input logic flip);
    logic nb;
    in_vld = vld;
    if (vld) begin
      nb     = ^(g & 8'hFE);
      g      = {g[6:0], nb};
      in_bit = nb ^ flip;
    end else begin
      in_bit = flip;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rst_   = 1'b0;
    in_vld = 1'b0;
    in_bit = 1'b0;
`ifdef PRBS_CHK_ERR_CLR_EN
    err_clr = 1'b0;
`endif
    g = 8'hA5;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  task automatic lock_up(input string tag);
    hard_reset();
    for (int i = 0; i < 23; i++) beat(1'b1, 1'b0);
    chk({tag, " locked after 23 beats"}, locked, 0);
    beat(1'b1, 1'b0);
    chk({tag, " locked after 24 beats"}, locked, 1);
    $display("%s: lock sequence done locked=%0b err_cnt=%0d", tag, locked, err_cnt);
  endtask

  initial begin
    int n;
    int vcount;
    int idle_pulse;
    logic v;

    // Lock from A5, one flipped bit, idle beats carrying garbage.
    for (int i = 0; i < 23; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'd0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'd1});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'd1});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'd1});
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'd1});

    rst_   = 1'b0;
    in_vld = 1'b0;
    in_bit = 1'b0;
`ifdef PRBS_CHK_ERR_CLR_EN
    err_clr = 1'b0;
`endif
    #12;
    chk("reset locked", locked, 0);
    chk("reset err_pulse", err_pulse, 0);
    chk("reset err_cnt", err_cnt, 0);

    hard_reset();
    foreach (tbl[i]) begin
      beat(tbl[i].vld, tbl[i].flip);
      $display("vec %0d vld=%0b flip=%0b locked=%0b pulse=%0b cnt=%0d", i, tbl[i].vld,
               tbl[i].flip, locked, err_pulse, err_cnt);
      chk($sformatf("vec %0d locked", i), locked, tbl[i].lk);
      chk($sformatf("vec %0d err_pulse", i), err_pulse, tbl[i].pl);
      chk($sformatf("vec %0d err_cnt", i), err_cnt, tbl[i].cnt);
    end

    // Four errors inside one window drop lock; relock after 8 + 16 clean beats.
    lock_up("loss");
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, k % 2 == 1);
      if (k == 5) chk("loss locked after 3 errors", locked, 1);
    end
    $display("loss: after 4th error locked=%0b pulse=%0b cnt=%0d cnt2=%0d", locked, err_pulse,
             err_cnt, err_cnt2);
    chk("loss locked after 4th error", locked, 0);
    chk("loss err_pulse on 4th error", err_pulse, 1);
    chk("loss err_cnt", err_cnt, 4);
    chk("loss dut2 still locked", locked2, 1);
    chk("loss dut2 err_cnt saturated", err_cnt2, 3);
    for (int i = 0; i < 23; i++) beat(1'b1, 1'b0);
    chk("relock not before 24 beats", locked, 0);
    beat(1'b1, 1'b0);
    chk("relock after 24 beats", locked, 1);
    chk("err_cnt kept across loss", err_cnt, 4);

    // Three errors in window 1, fourth on the wrap beat lands in window 2.
    lock_up("win");
    n = 0;
    for (int k = 0; k < 64; k++) begin
      beat(1'b1, (k == 10) || (k == 20) || (k == 30) || (k == 63));
      if (err_pulse) n++;
      if (k == 30) chk("win err_cnt after 3", err_cnt, 3);
    end
    $display("win: after wrap error locked=%0b cnt=%0d pulses=%0d", locked, err_cnt, n);
    chk("win locked held", locked, 1);
    chk("win err_cnt", err_cnt, 4);
    chk("win pulse count", n, 4);
    beat(1'b1, 1'b0);
    chk("win locked after next beat", locked, 1);

    // Stalls: every other cycle idle; lock still needs 24 valid beats.
    hard_reset();
    vcount     = 0;
    idle_pulse = 0;
    for (int i = 0; i < 48; i++) begin
      v = (i % 2 == 0);
      beat(v, !v);
      if (!v && err_pulse) idle_pulse++;
      if (v) begin
        vcount++;
        if (vcount == 23) chk("stall locked at 23 valid", locked, 0);
        if (vcount == 24) chk("stall locked at 24 valid", locked, 1);
      end
    end
    $display("stall: valid=%0d locked=%0b idle_pulses=%0d", vcount, locked, idle_pulse);
    chk("stall locked held over idle", locked, 1);
    chk("stall idle pulses", idle_pulse, 0);
    chk("stall err_cnt", err_cnt, 0);

    // Constant-zero stream must never lock.
    hard_reset();
    n = 0;
    in_vld = 1'b1;
    in_bit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (locked) n++;
    end
    $display("zeros: locked cycles=%0d", n);
    chk("zeros never locked", n, 0);

    // Asynchronous reset mid-lock, between clock edges.
    lock_up("arst");
    beat(1'b1, 1'b1);
    chk("arst err_cnt before reset", err_cnt, 1);
    in_vld = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    $display("arst: during reset locked=%0b pulse=%0b cnt=%0d", locked, err_pulse, err_cnt);
    chk("arst locked", locked, 0);
    chk("arst err_pulse", err_pulse, 0);
    chk("arst err_cnt", err_cnt, 0);
    g = 8'hA5;
    #2;
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) beat(1'b1, 1'b0);
    chk("arst relock not before 24", locked, 0);
    beat(1'b1, 1'b0);
    chk("arst relock at 24", locked, 1);

`ifdef PRBS_CHK_ERR_CLR_EN
    lock_up("clr");
    beat(1'b1, 1'b1);
    chk("clr err_cnt before clear", err_cnt, 1);
    err_clr = 1'b1;
    beat(1'b1, 1'b1);
    $display("clr: clear+error locked=%0b pulse=%0b cnt=%0d", locked, err_pulse, err_cnt);
    chk("clr wins over increment", err_cnt, 0);
    chk("clr err_pulse still", err_pulse, 1);
    chk("clr locked unaffected", locked, 1);
    err_clr = 1'b0;
    beat(1'b1, 1'b0);
    chk("clr err_cnt stays 0", err_cnt, 0);
    chk("clr locked after", locked, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_chk.md
PRBS_CHK -- requirements
Module: prbs_chk

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter LOCK_CNT, default 16: consecutive matching beats required to lock.
REQ-003 Parameter LOSS_WIN, default 64: loss-detection window length, in valid beats.
REQ-004 Parameter LOSS_THR, default 4: mismatches within one window that force loss of lock.
REQ-005 Parameter ERR_W, default 16: error counter width.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_  input  1  asynchronous active-low reset.
REQ-008 in_bit  input  1  received stream bit, taken from generator PRN[0].
REQ-009 in_vld  input  1  in_bit qualifier; no activity occurs on beats where in_vld=0.
REQ-010 locked  output  1  registered lock indication.
REQ-011 err_pulse  output  1  one-cycle pulse on each mismatch while locked.
REQ-012 err_cnt  output  ERR_W  saturating count of mismatches seen while locked.

Function
REQ-013 Polynomial SHALL match the upstream 8-bit generator: shift register sr[7:0] shifts up and inserts at sr[0]; predicted bit = XOR of sr[7:1].
REQ-014 States SHALL be FILL, SEARCH and LOCKED; encoding is registered, one state per cycle.
REQ-015 FILL: each valid beat shifts in_bit into sr, with no compare; after the 8th beat the state SHALL move to SEARCH.
REQ-016 SEARCH compare: each valid beat compares in_bit to the predicted bit, then shifts in_bit into sr.
REQ-017 SEARCH match counting: a match increments match_cnt; a mismatch clears match_cnt to 0.
REQ-018 SEARCH all-zero guard: a match with sr==8'h00 before the shift SHALL clear match_cnt rather than increment it (all-zero lock-up guard).
REQ-019 The LOCK_CNT-th consecutive match SHALL move the state to LOCKED, with locked=1 on the following cycle (1-cycle latency).
REQ-020 LOCKED shifting: sr SHALL shift in the predicted bit, not in_bit, so a single bit error causes exactly one mismatch.
REQ-021 LOCKED mismatch: err_pulse=1 on the cycle after the mismatching beat, err_cnt increments, and it saturates at all-ones.
REQ-022 LOCKED window: win_cnt counts valid beats from 0 to LOSS_WIN-1 and then wraps; win_err counts mismatches within the window.
REQ-023 Window wrap: win_err clears to 0 at wrap; a mismatch on the wrap beat counts as 1 in the new window.
REQ-024 Loss of lock: win_err reaching LOSS_THR SHALL move the state to FILL and clear locked, match_cnt, win_cnt and win_err on the next cycle; err_cnt is retained.
REQ-025 The loss-triggering mismatch SHALL still produce err_pulse and increment err_cnt.
REQ-026 in_vld=0 SHALL hold all state, counters and sr, and keep err_pulse=0.

Reset
REQ-027 rst_ low SHALL immediately force state=FILL, sr=0, fill/match/win/win_err counters=0, locked=0, err_pulse=0 and err_cnt=0, regardless of clk.
REQ-028 Reset mid-lock SHALL discard all history; after release, relock requires 8+LOCK_CNT valid beats.

Configuration
REQ-029 Macro PRBS_CHK_ERR_CLR_EN defined: adds input err_clr (1 bit), which synchronously zeroes err_cnt.
REQ-030 err_clr precedence: err_clr SHALL win over a simultaneous increment, and SHALL NOT affect state, locked or the window counters.
REQ-031 Macro PRBS_CHK_ERR_CLR_EN undefined: the port is absent and err_cnt clears only on reset.

Structure
REQ-032 Shared package lfsr_pkg SHALL hold the LFSR width constant (8), the tap mask constant 8'hFE and the checker state enum; the upstream generator uses the same constants.
REQ-033 One sub-module, prbs_sat_cnt (parameterised width, increment, synchronous clear, saturation), SHALL implement err_cnt.

Verification
REQ-034 Lock: reset, then 24 valid beats from a generator loaded with 8'hA5 -> locked=1 the cycle after beat 24, err_cnt=0.
REQ-035 Single error: locked, flip one bit -> exactly one err_pulse, err_cnt=1, locked stays 1.
REQ-036 Loss: 4 flipped bits within 64 beats -> locked=0 the cycle after the 4th error, err_cnt=4, relock 24 beats later.
REQ-037 Window wrap: 3 errors in window 1, then 1 error in the next window's first beat -> lock held, err_cnt=4.
REQ-038 Stalls and zeros: in_vld toggling 1/0 during lock -> identical lock beat count and no err_pulse on idle cycles; a constant-zero stream -> locked never asserts.
REQ-039 Reset and clear: rst_ pulsed low mid-lock, asynchronous to clk -> outputs 0 immediately; with PRBS_CHK_ERR_CLR_EN, err_clr and an error on the same beat -> err_cnt=0.
